vram_arb: RTL and testbench

- Initiator side of the VRAM word interface: the single master driving the VRAM memory block's clk/wr_en/wr_mask/address/data ports.
- Arbitrates three requesters by fixed priority:
  - video generator fetch (read-only, never stalled)
  - host register interface (read/write, handshake)
  - blitter (read/write, handshake)
- Registers the winning request onto the VRAM port, tracks ownership through the 1-cycle VRAM read latency and returns data/acks to the owner.
- Sits between the video/register/blit logic and vram in the top level.

---
 rtl/xosera_pkg.sv | 14 +
 rtl/vram_req_port.sv | 59 +++++
 rtl/vram_arb.sv | 137 +++++++++++++
 tb/tb_vram_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_pkg.sv
// Shared Xosera types: VRAM address/word widths and the VRAM pipeline owner tag.
package xosera_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGEN = 2'd1,
        OWN_REGS = 2'd2,
        OWN_BLIT = 2'd3
    } vram_owner_t;

endpackage

// File: rtl/vram_req_port.sv
// One handshake requester's side of the VRAM arbiter: busy flag, ack pulse
// and the read-data hold register.
module vram_req_port
    import xosera_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        grant_i,
    input  logic        wr_i,
    input  logic        done_i,
    input  logic [15:0] rdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [15:0] data_o
);

    logic  busy_q, busy_d;
    logic  ack_q, ack_d;
    logic  wr_q, wr_d;
    word_t data_q, data_d;

    // done_i marks stage2 ownership; grant and done never coincide for one port
    // because the next grant is only possible after the ack cycle.
    always_comb begin
        busy_d = busy_q;
        wr_d   = wr_q;
        data_d = data_q;
        ack_d  = done_i;
        if (grant_i) begin
            busy_d = 1'b1;
            wr_d   = wr_i;
        end
        if (done_i) begin
            busy_d = 1'b0;
            if (!wr_q) begin
                data_d = rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            ack_q  <= ack_d;
            wr_q   <= wr_d;
            data_q <= data_d;
        end
    end

    assign busy_o = busy_q;
    assign ack_o  = ack_q;
    assign data_o = data_q;

endmodule

// File: rtl/vram_arb.sv
// VRAM port master: fixed-priority arbitration (vgen > regs > blit) with owner
// tracking through the one-cycle VRAM read latency.
module vram_arb
    import xosera_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        vgen_sel,
    input  logic [15:0] vgen_addr,
    output logic [15:0] vgen_data,
    input  logic        regs_sel,
    input  logic        regs_wr,
    input  logic [3:0]  regs_mask,
    input  logic [15:0] regs_addr,
    input  logic [15:0] regs_data_in,
    output logic        regs_ack,
    output logic [15:0] regs_data_out,
    input  logic        blit_sel,
    input  logic        blit_wr,
    input  logic [3:0]  blit_mask,
    input  logic [15:0] blit_addr,
    input  logic [15:0] blit_data_in,
    output logic        blit_ack,
    output logic [15:0] blit_data_out,
    output logic        vram_wr_en,
    output logic [3:0]  vram_wr_mask,
    output logic [15:0] vram_addr,
    output logic [15:0] vram_data_out,
    input  logic [15:0] vram_data_in
);

    vram_owner_t win;
    vram_owner_t stage1_q, stage1_d;
    vram_owner_t stage2_q, stage2_d;

    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_mask_q, wr_mask_d;
    addr_t       addr_q, addr_d;
    word_t       wdata_q, wdata_d;

    logic        regs_busy, blit_busy;
    logic        regs_elig, blit_elig;

    // A port in its ack cycle is not eligible, so a held sel is not re-granted.
    assign regs_elig = regs_sel && !regs_busy && !regs_ack;
    assign blit_elig = blit_sel && !blit_busy && !blit_ack;

    always_comb begin
        win = OWN_NONE;
        if (vgen_sel) begin
            win = OWN_VGEN;
        end else if (regs_elig) begin
            win = OWN_REGS;
        end else if (blit_elig) begin
            win = OWN_BLIT;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_mask_d = wr_mask_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (win)
            OWN_VGEN: begin
                addr_d = vgen_addr;
            end
            OWN_REGS: begin
                wr_en_d   = regs_wr;
                wr_mask_d = regs_mask;
                addr_d    = regs_addr;
                wdata_d   = regs_data_in;
            end
            OWN_BLIT: begin
                wr_en_d   = blit_wr;
                wr_mask_d = blit_mask;
                addr_d    = blit_addr;
                wdata_d   = blit_data_in;
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
        stage1_d = win;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_mask_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            stage1_q  <= OWN_NONE;
            stage2_q  <= OWN_NONE;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_mask_q <= wr_mask_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            stage1_q  <= stage1_d;
            stage2_q  <= stage2_d;
        end
    end

    vram_req_port u_regs_port (
        .clk     (clk),
        .reset   (reset),
        .grant_i (win == OWN_REGS),
        .wr_i    (regs_wr),
        .done_i  (stage2_q == OWN_REGS),
        .rdata_i (vram_data_in),
        .busy_o  (regs_busy),
        .ack_o   (regs_ack),
        .data_o  (regs_data_out)
    );

    vram_req_port u_blit_port (
        .clk     (clk),
        .reset   (reset),
        .grant_i (win == OWN_BLIT),
        .wr_i    (blit_wr),
        .done_i  (stage2_q == OWN_BLIT),
        .rdata_i (vram_data_in),
        .busy_o  (blit_busy),
        .ack_o   (blit_ack),
        .data_o  (blit_data_out)
    );

    // Video data is the raw VRAM read bus; vgen owns it two cycles after its request.
    assign vgen_data     = vram_data_in;
    assign vram_wr_en    = wr_en_q;
    assign vram_wr_mask  = wr_mask_q;
    assign vram_addr     = addr_q;
    assign vram_data_out = wdata_q;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: behavioural VRAM, cycle-indexed expectation tables built
// from grant timing rules, directed scenarios then randomized traffic.
module tb_vram_arb;

    localparam int NC = 4096;

    logic        clk;
    logic        reset;
    logic        vgen_sel;
    logic [15:0] vgen_addr;
    logic [15:0] vgen_data;
    logic        regs_sel, regs_wr;
    logic [3:0]  regs_mask;
    logic [15:0] regs_addr, regs_data_in, regs_data_out;
    logic        regs_ack;
    logic        blit_sel, blit_wr;
    logic [3:0]  blit_mask;
    logic [15:0] blit_addr, blit_data_in, blit_data_out;
    logic        blit_ack;
    logic        vram_wr_en;
    logic [3:0]  vram_wr_mask;
    logic [15:0] vram_addr, vram_data_out, vram_data_in;

    vram_arb dut (
        .clk           (clk),
        .reset         (reset),
        .vgen_sel      (vgen_sel),
        .vgen_addr     (vgen_addr),
        .vgen_data     (vgen_data),
        .regs_sel      (regs_sel),
        .regs_wr       (regs_wr),
        .regs_mask     (regs_mask),
        .regs_addr     (regs_addr),
        .regs_data_in  (regs_data_in),
        .regs_ack      (regs_ack),
        .regs_data_out (regs_data_out),
        .blit_sel      (blit_sel),
        .blit_wr       (blit_wr),
        .blit_mask     (blit_mask),
        .blit_addr     (blit_addr),
        .blit_data_in  (blit_data_in),
        .blit_ack      (blit_ack),
        .blit_data_out (blit_data_out),
        .vram_wr_en    (vram_wr_en),
        .vram_wr_mask  (vram_wr_mask),
        .vram_addr     (vram_addr),
        .vram_data_out (vram_data_out),
        .vram_data_in  (vram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [3:0] mask);
        logic [15:0] r;
        r = old_w;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) r[4*n +: 4] = new_w[4*n +: 4];
        end
        return r;
    endfunction

    // Behavioural VRAM: registered read, nibble-masked write, no reset.
    logic [15:0] mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] vram_rd_q;
    logic        load;
    assign vram_data_in = vram_rd_q;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
        end else begin
            if (vram_wr_en) mem[vram_addr] <= merge(mem[vram_addr], vram_data_out, vram_wr_mask);
            vram_rd_q <= mem[vram_addr];
        end
    end

    int checks, errors, cyc;

    bit          e_wen [NC];
    logic [15:0] e_addr [NC];
    bit          e_wchk [NC];
    logic [3:0]  e_wmask [NC];
    logic [15:0] e_wdata [NC];
    bit          e_rack [NC], e_back [NC];
    bit          e_rnew [NC], e_bnew [NC];
    logic [15:0] e_rval [NC], e_bval [NC];
    bit          e_vchk [NC];
    logic [15:0] e_vval [NC];

    logic [15:0] m_rdata, m_bdata, m_last_addr;
    int          r_next_ok, b_next_ok, r_ack_cyc, b_ack_cyc;
    bit          r_granted, b_granted;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Schedule the visible effects of a handshake grant in cycle c.
    task automatic issue(input int c, input bit is_blit, input logic wr, input logic [3:0] mask,
                         input logic [15:0] addr, input logic [15:0] data);
        e_addr[c+1] = addr;
        if (wr) begin
            e_wen[c+1]   = 1'b1;
            e_wchk[c+1]  = 1'b1;
            e_wmask[c+1] = mask;
            e_wdata[c+1] = data;
            ref_mem[addr] = merge(ref_mem[addr], data, mask);
        end
        if (!is_blit) begin
            if (!wr) begin e_rnew[c+3] = 1'b1; e_rval[c+3] = ref_mem[addr]; end
            e_rack[c+3] = 1'b1;
            r_next_ok = c + 4; r_granted = 1'b1; r_ack_cyc = c + 3;
        end else begin
            if (!wr) begin e_bnew[c+3] = 1'b1; e_bval[c+3] = ref_mem[addr]; end
            e_back[c+3] = 1'b1;
            b_next_ok = c + 4; b_granted = 1'b1; b_ack_cyc = c + 3;
        end
    endtask

    task automatic model_eval();
        int c;
        c = cyc;
        if (reset) begin
            for (int k = c + 1; k <= c + 4; k++) begin
                e_wen[k] = 0; e_wchk[k] = 0; e_rack[k] = 0; e_back[k] = 0;
                e_rnew[k] = 0; e_bnew[k] = 0; e_vchk[k] = 0;
            end
            e_addr[c+1] = '0;
            e_wchk[c+1] = 1'b1; e_wmask[c+1] = '0; e_wdata[c+1] = '0;
            e_rnew[c+1] = 1'b1; e_rval[c+1] = '0;
            e_bnew[c+1] = 1'b1; e_bval[c+1] = '0;
            m_last_addr = '0;
            r_next_ok = c + 1; b_next_ok = c + 1;
            r_granted = 1'b0; b_granted = 1'b0;
            return;
        end
        e_wen[c+1]  = 1'b0;
        e_addr[c+1] = m_last_addr;
        if (vgen_sel) begin
            e_addr[c+1] = vgen_addr;
            e_vchk[c+2] = 1'b1;
            e_vval[c+2] = ref_mem[vgen_addr];
        end else if (regs_sel && c >= r_next_ok) begin
            issue(c, 1'b0, regs_wr, regs_mask, regs_addr, regs_data_in);
        end else if (blit_sel && c >= b_next_ok) begin
            issue(c, 1'b1, blit_wr, blit_mask, blit_addr, blit_data_in);
        end
        m_last_addr = e_addr[c+1];
    endtask

    task automatic check_cycle();
        int c;
        c = cyc;
        if (e_rnew[c]) m_rdata = e_rval[c];
        if (e_bnew[c]) m_bdata = e_bval[c];
        chk("vram_wr_en", {15'd0, vram_wr_en}, {15'd0, e_wen[c]});
        chk("vram_addr", vram_addr, e_addr[c]);
        chk("regs_ack", {15'd0, regs_ack}, {15'd0, e_rack[c]});
        chk("blit_ack", {15'd0, blit_ack}, {15'd0, e_back[c]});
        chk("regs_data_out", regs_data_out, m_rdata);
        chk("blit_data_out", blit_data_out, m_bdata);
        if (e_wchk[c]) begin
            chk("vram_wr_mask", {12'd0, vram_wr_mask}, {12'd0, e_wmask[c]});
            chk("vram_data_out", vram_data_out, e_wdata[c]);
        end
        if (e_vchk[c]) chk("vgen_data", vgen_data, e_vval[c]);
    endtask

    // Inputs set for the current cycle are evaluated, then outputs of the next cycle checked.
    task automatic next_cycle();
        model_eval();
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic regs_set(input logic wr, input logic [3:0] mask, input logic [15:0] addr,
                            input logic [15:0] data);
        regs_sel = 1'b1; regs_wr = wr; regs_mask = mask; regs_addr = addr; regs_data_in = data;
    endtask

    task automatic blit_set(input logic wr, input logic [3:0] mask, input logic [15:0] addr,
                            input logic [15:0] data);
        blit_sel = 1'b1; blit_wr = wr; blit_mask = mask; blit_addr = addr; blit_data_in = data;
    endtask

    bit r_active, b_active;
    int vgen_pct;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_rdata = '0; m_bdata = '0; m_last_addr = '0;
        r_next_ok = 0; b_next_ok = 0; r_ack_cyc = 0; b_ack_cyc = 0;
        r_granted = 0; b_granted = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
        ref_mem[16'h1234] = 16'hABCD;
        ref_mem[16'h0010] = 16'hFFFF;
        ref_mem[16'h0001] = 16'h1111;
        ref_mem[16'h0002] = 16'h2222;
        vgen_sel = 0; vgen_addr = '0;
        regs_sel = 0; regs_wr = 0; regs_mask = '0; regs_addr = '0; regs_data_in = '0;
        blit_sel = 0; blit_wr = 0; blit_mask = '0; blit_addr = '0; blit_data_in = '0;
        reset = 1'b1; load = 1'b1;
        next_cycle();
        load = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();

        // Regs read of 0x1234
        regs_set(1'b0, 4'h0, 16'h1234, 16'h0000);
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        chk("regs_read_value", regs_data_out, 16'hABCD);
        repeat (2) next_cycle();

        // Masked regs write then readback
        regs_set(1'b1, 4'b0011, 16'h0010, 16'h5A5A);
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        chk("regs_write_hold", regs_data_out, 16'hABCD);
        next_cycle();
        regs_set(1'b0, 4'h0, 16'h0010, 16'h0000);
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        chk("regs_readback", regs_data_out, 16'hFF5A);
        next_cycle();

        // vgen and regs in the same cycle
        vgen_sel = 1'b1; vgen_addr = 16'h0100;
        regs_set(1'b0, 4'h0, 16'h0200, 16'h0000);
        next_cycle();
        vgen_sel = 1'b0;
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        next_cycle();

        // regs and blit in the same cycle
        regs_set(1'b0, 4'h0, 16'h0001, 16'h0000);
        blit_set(1'b0, 4'h0, 16'h0002, 16'h0000);
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        next_cycle();
        blit_sel = 1'b0;
        chk("regs_own_word", regs_data_out, 16'h1111);
        chk("blit_own_word", blit_data_out, 16'h2222);
        next_cycle();

        // vgen starves a pending blit for 10 cycles
        blit_set(1'b0, 4'h0, 16'h0003, 16'h0000);
        vgen_sel = 1'b1;
        repeat (10) begin
            vgen_addr = 16'($urandom_range(0, 255));
            next_cycle();
        end
        vgen_sel = 1'b0;
        repeat (4) next_cycle();
        blit_sel = 1'b0;
        next_cycle();

        // Reset in G+1 of a regs read, then a fresh read
        regs_set(1'b0, 4'h0, 16'h0005, 16'h0000);
        next_cycle();
        reset = 1'b1; regs_sel = 1'b0;
        next_cycle();
        reset = 1'b0;
        repeat (5) next_cycle();
        regs_set(1'b0, 4'h0, 16'h1234, 16'h0000);
        repeat (4) next_cycle();
        regs_sel = 1'b0;
        chk("read_after_reset", regs_data_out, 16'hABCD);
        next_cycle();

        // Randomized traffic with occasional resets
        r_active = 0; b_active = 0;
        for (int i = 0; i < 2000; i++) begin
            vgen_pct = (i < 1000) ? 35 : 75;
            if (r_active && r_granted && cyc > r_ack_cyc) r_active = 0;
            if (b_active && b_granted && cyc > b_ack_cyc) b_active = 0;
            if (!r_active && $urandom_range(0, 2) == 0) begin
                r_active = 1; r_granted = 0;
                regs_wr = 1'($urandom_range(0, 1)); regs_mask = 4'($urandom);
                regs_addr = 16'($urandom_range(0, 63)); regs_data_in = 16'($urandom);
            end
            if (!b_active && $urandom_range(0, 2) == 0) begin
                b_active = 1; b_granted = 0;
                blit_wr = 1'($urandom_range(0, 1)); blit_mask = 4'($urandom);
                blit_addr = 16'($urandom_range(0, 63)); blit_data_in = 16'($urandom);
            end
            vgen_sel  = ($urandom_range(0, 99) < vgen_pct);
            vgen_addr = 16'($urandom_range(0, 63));
            reset     = ($urandom_range(0, 249) == 0);
            if (reset) begin r_active = 0; b_active = 0; end
            regs_sel = r_active;
            blit_sel = b_active;
            next_cycle();
        end
        reset = 1'b0; regs_sel = 1'b0; blit_sel = 1'b0; vgen_sel = 1'b0;
        repeat (5) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
